dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port synchronous data RAM (read latency 1) between the CPU
// data port and a debug/loader port.
//
// Arbitration:
//   - The CPU normally wins when both ports request. Every cycle the debug
//     port is denied, a wait counter advances. Once that counter reaches
//     MAX_WAIT, the debug port wins the next contended cycle.
//   - A debug grant with dbg_lock=1 enters LOCK. In LOCK only the debug port
//     is served. The first cycle with dbg_lock=0 is arbitrated normally, and
//     the block returns to ARB on the following edge.
//   - Read data returns one cycle after the grant. It is steered to the
//     owner of that read and is forced to 0 whenever that port's rvalid is low.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU access request
//   cpu_gnt, cpu_stall            CPU grant this cycle; stall = req & ~gnt
//   cpu_rvalid, cpu_rdata         CPU read return (one cycle after grant)
//   dbg_req/we/lock/addr/wdata    debug access request, lock request
//   dbg_gnt, dbg_rvalid, dbg_rdata  debug grant and read return
//   mem_en/we/addr/wdata          RAM request port
//   mem_rdata                     RAM read data (latency 1)
//   cpu_gnt_cnt, dbg_gnt_cnt      saturating 16-bit grant counters
//
// Configuration:
//   DMEM_ARB_STATS_EN  When defined, the grant counters are implemented.
//                      When undefined, both counter outputs are tied to 0
//                      and no counter flops exist.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       cpu_gnt_cnt,
    output logic [15:0]       dbg_gnt_cnt
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_nxt;
    logic        w_arb_rules;
    logic        r_cpu_rvalid;
    logic        r_dbg_rvalid;

    function automatic logic [3:0] sat_inc_wait(input logic [3:0] v);
        if (v >= WAIT_LIM) begin
            return WAIT_LIM;
        end
        return v + 4'd1;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Grant decision and next state. A LOCK cycle with dbg_lock low is
    // arbitrated as if in ARB; this is the cycle that releases the lock.
    always_comb begin
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;
        w_state_nxt = r_state;
        w_arb_rules = (r_state == ARB) || !dbg_lock;
        if (!rst) begin
            if (w_arb_rules) begin
                if (cpu_req && dbg_req) begin
                    if (r_wait_cnt == WAIT_LIM) begin
                        dbg_gnt = 1'b1;
                    end else begin
                        cpu_gnt = 1'b1;
                    end
                end else begin
                    cpu_gnt = cpu_req;
                    dbg_gnt = dbg_req;
                end
            end else begin
                dbg_gnt = dbg_req;
            end
        end
        case (r_state)
            ARB:     if (dbg_gnt && dbg_lock) w_state_nxt = LOCK;
            LOCK:    if (!dbg_lock)           w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    assign w_wait_nxt = (dbg_req && !dbg_gnt) ? sat_inc_wait(r_wait_cnt) : 4'd0;
    assign cpu_stall  = cpu_req & ~cpu_gnt;

    // Memory request mux
    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Read-return tracking: one flag per port marks the owner of the read
    // issued last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= cpu_gnt & ~cpu_we;
            r_dbg_rvalid <= dbg_gnt & ~dbg_we;
        end
    end

    // The reset gate keeps a read issued just before reset from being
    // presented while reset is held.
    assign cpu_rvalid = r_cpu_rvalid & ~rst;
    assign dbg_rvalid = r_dbg_rvalid & ~rst;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_cpu_gnt_cnt;
    logic [15:0] r_dbg_gnt_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    // Grant statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_gnt_cnt <= 16'd0;
            r_dbg_gnt_cnt <= 16'd0;
        end else begin
            if (cpu_gnt) r_cpu_gnt_cnt <= sat_inc16(r_cpu_gnt_cnt);
            if (dbg_gnt) r_dbg_gnt_cnt <= sat_inc16(r_dbg_gnt_cnt);
        end
    end

    assign cpu_gnt_cnt = r_cpu_gnt_cnt;
    assign dbg_gnt_cnt = r_dbg_gnt_cnt;
`else
    assign cpu_gnt_cnt = 16'd0;
    assign dbg_gnt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   cpu_gnt_cnt, dbg_gnt_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt)
    );

    // Environment RAM driven only by the DUT's memory port.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct packed {
        logic          cg, dg, stall, en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          crv;
        logic [DW-1:0] crd;
        logic          drv;
        logic [DW-1:0] drd;
        logic          chk_cnt;
        logic [15:0]   ccnt, dcnt;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DW-1:0] mref [0:(1<<AW)-1];
    bit            m_locked = 0;
    int            m_waited = 0;
    int            m_ccnt = 0, m_dcnt = 0;
    bit            cnt_known = 0;
    bit            pc = 0, pd = 0;
    logic [DW-1:0] pcd = '0, pdd = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("cpu_gnt",    32'(cpu_gnt),    32'(e.cg));
            chk("dbg_gnt",    32'(dbg_gnt),    32'(e.dg));
            chk("cpu_stall",  32'(cpu_stall),  32'(e.stall));
            chk("mem_en",     32'(mem_en),     32'(e.en));
            chk("mem_we",     32'(mem_we),     32'(e.we));
            chk("mem_addr",   32'(mem_addr),   32'(e.addr));
            chk("mem_wdata",  mem_wdata,       e.wdata);
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.crv));
            chk("cpu_rdata",  cpu_rdata,       e.crd);
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e.drv));
            chk("dbg_rdata",  dbg_rdata,       e.drd);
            if (e.chk_cnt) begin
                chk("cpu_gnt_cnt", 32'(cpu_gnt_cnt), 32'(e.ccnt));
                chk("dbg_gnt_cnt", 32'(dbg_gnt_cnt), 32'(e.dcnt));
            end
        end
    end

    // One clock cycle: drive inputs, predict the response, advance the model.
    task automatic step(input bit r, input bit cr, input bit cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input bit dr, input bit dw, input bit dl,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
        exp_t e;
        bit gc, gd;
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
        gc = 0; gd = 0;
        if (!r) begin
            if (m_locked && dl) begin
                gd = dr;
            end else if (cr && dr) begin
                gd = (m_waited == MW);
                gc = !gd;
            end else begin
                gc = cr;
                gd = dr;
            end
        end
        e = '0;
        e.cg = gc; e.dg = gd; e.stall = cr && !gc; e.en = gc || gd;
        if (gc) begin
            e.we = cw; e.addr = ca; e.wdata = cd;
        end else if (gd) begin
            e.we = dw; e.addr = da; e.wdata = dd;
        end
        e.crv = pc && !r; e.crd = e.crv ? pcd : '0;
        e.drv = pd && !r; e.drd = e.drv ? pdd : '0;
        e.chk_cnt = cnt_known && !r;
`ifdef DMEM_ARB_STATS_EN
        e.ccnt = 16'(m_ccnt); e.dcnt = 16'(m_dcnt);
`else
        e.ccnt = 16'd0; e.dcnt = 16'd0;
`endif
        q.push_back(e);
        if (r) begin
            m_locked = 0; m_waited = 0; pc = 0; pd = 0;
            m_ccnt = 0; m_dcnt = 0; cnt_known = 1;
        end else begin
            pc = gc && !cw; pcd = mref[ca];
            pd = gd && !dw; pdd = mref[da];
            if (gc && cw) mref[ca] = cd;
            if (gd && dw) mref[da] = dd;
            m_waited = (dr && !gd) ? ((m_waited < MW) ? m_waited + 1 : MW) : 0;
            if (!dl) m_locked = 0;
            else if (gd) m_locked = 1;
            if (gc && m_ccnt < 65535) m_ccnt++;
            if (gd && m_dcnt < 65535) m_dcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        logic [DW-1:0] v;
        bit lk;
        for (int i = 0; i < (1 << AW); i++) begin
            v = $urandom;
            ram[i] = v;
            mref[i] = v;
        end
        ram[5] = 32'h1234_5678;
        mref[5] = 32'h1234_5678;
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        step(1, 1, 0, 10'h7, '0, 1, 0, 0, 10'h8, '0);
        // CPU read of a known word
        step(0, 1, 0, 10'h005, '0, 0, 0, 0, '0, '0);
        idle();
        // Contention with the fairness limit
        for (int i = 0; i < 8; i++) step(0, 1, 0, 10'(i), '0, 1, 0, 0, 10'h8, '0);
        idle();
        // Locked debug write then reads while CPU waits, then release
        step(0, 0, 0, '0, '0, 1, 1, 1, 10'h3FF, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 10'h0, '0, 1, 0, 1, 10'h3FF, '0);
        step(0, 1, 0, 10'h0, '0, 0, 0, 0, '0, '0);
        idle();
        // Alternating owners, back-to-back reads
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) step(0, 1, 0, 10'h1, '0, 0, 0, 0, '0, '0);
            else            step(0, 0, 0, '0, '0, 1, 0, 0, 10'h2, '0);
        end
        idle();
        // Reset right after a granted read, then contention from a clean state
        step(0, 1, 0, 10'h5, '0, 0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 10'h3, '0, 1, 0, 0, 10'h4, '0);
        idle();
        // Randomized traffic
        lk = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) lk = !lk;
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                 10'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 1), lk,
                 ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15)),
                 $urandom);
        end
        idle();
`ifdef DMEM_ARB_STATS_EN
        // Counter saturation
        step(1, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 32'h10001; i++) step(0, 1, 0, 10'($urandom_range(0, 15)), '0, 0, 0, 0, '0, '0);
        idle();
`endif
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
